reg_file_rename: RTL and testbench
==================================

Name: reg_file_rename

Overview:
- Architectural register file with per-register rename tags for the Tomasulo core.
- Sits on the other end of the ROB's commit and search interfaces:
  - consumes ROB commits to update architectural state;
  - drives ROB search requests to resolve operand dependencies at issue.
- Serves the decoder/RS issue path with either ready operand values or the ROB id to wait on.

Parameters:
- ROB_WIDTH, 3, bits of a ROB entry id; ROB has 2**ROB_WIDTH entries.

Ports:
- clk_in  in  1  system clock.
- rst_in  in  1  reset; asynchronous, active-high.
- rdy_in  in  1  global ready; when low, no state changes.
- clear  in  1  mispredict flush from ROB; acts at the clock edge when rdy_in=1.
- dec_ready  in  1  decoder issues an instruction this cycle.
- dec_rs1  in  5  source register 1 index.
- dec_rs2  in  5  source register 2 index.
- dec_rd  in  5  destination register index; 0 means no rename.
- dec_rob_id  in  ROB_WIDTH  ROB entry allocated to the issuing instruction (ROB empty_rob_id).
- val1  out  32  operand 1 value; valid when dep1_valid=0.
- dep1_valid  out  1  operand 1 still pending.
- dep1  out  ROB_WIDTH  ROB id producing operand 1.
- val2, dep2_valid, dep2  out  32/1/ROB_WIDTH  same for operand 2.
- search_rob_id_1  out  ROB_WIDTH  ROB lookup id for operand 1.
- search_rob_id_2  out  ROB_WIDTH  ROB lookup id for operand 2.
- search_ready_1  in  1  ROB result available for search_rob_id_1.
- search_val_1  in  32  ROB value for search_rob_id_1.
- search_ready_2, search_val_2  in  1/32  same for search 2.
- commit_ready  in  1  ROB commits a register write.
- commit_rob_id  in  ROB_WIDTH  ROB id being committed.
- commit_reg_id  in  5  destination register.
- commit_val  in  32  committed value.

Behaviour:
- State per register r (0..31): value[r] (32b), busy[r] (1b), tag[r] (ROB_WIDTH).
- Reset (async, rst_in=1): all value=0, busy=0, tag=0.
  - Resulting outputs: dep*_valid=0, val*=0, search ids=0.
- x0: value reads 0; never busy; writes to r=0 ignored (commit or rename).
- Operand read is combinational, same cycle as dec_ready. Outputs are driven every cycle regardless of dec_ready. Per operand i with index s, priority order:
  1. s==0 -> val=0, dep_valid=0.
  2. busy[s]=0 -> val=value[s], dep_valid=0.
  3. commit_ready && commit_reg_id==s && commit_rob_id==tag[s] -> val=commit_val, dep_valid=0 (commit bypass).
  4. search_ready_i=1 -> val=search_val_i, dep_valid=0.
  5. Otherwise -> dep_valid=1, dep=tag[s], val=0.
- search_rob_id_i = tag[dec_rsi] always; it is meaningful only when busy.
- Sources read pre-issue state: an instruction with rd==rs1 sees the old mapping, not its own tag.
- Sequential update at posedge clk_in when rdy_in=1 (nothing changes when rdy_in=0):
  - Commit, when commit_ready && commit_reg_id!=0:
    - value[commit_reg_id] <= commit_val unconditionally.
    - busy cleared only if tag[commit_reg_id]==commit_rob_id, i.e. no younger rename pending.
  - Rename, when dec_ready && dec_rd!=0 && !clear:
    - busy[dec_rd] <= 1, tag[dec_rd] <= dec_rob_id.
  - Same-cycle commit and rename to the same register: rename wins for busy/tag (busy stays 1 with the new tag); the value is still written.
  - clear=1:
    - all busy <= 0; values retained.
    - A same-cycle commit still writes its value.
    - A same-cycle dec_ready rename is dropped.
- Tags wrap with the ROB (modulo 2**ROB_WIDTH). Stale matches are impossible because the ROB never holds 2**ROB_WIDTH live entries.
- Reset asserted mid-operation: immediate asynchronous return to the reset state; any in-flight commit is lost.

Test Plan:
- Reset, then read rs1=5, rs2=0 -> val1=0, val2=0, dep1_valid=0, dep2_valid=0.
- Issue rd=3 rob_id=2; next cycle read rs1=3 with search_ready_1=0 -> dep1_valid=1, dep1=2, search_rob_id_1=2. Then assert search_ready_1=1, search_val_1=0x55 -> val1=0x55, dep1_valid=0.
- Rename x3->tag 2, then commit rob 2, reg 3, val 0x1234 -> next cycle busy cleared and read x3 gives 0x1234. In the commit cycle itself, read x3 gives 0x1234 via bypass.
- Rename x4->tag 1, then x4->tag 5; commit rob 1, reg 4, val 7 -> value=7 but dep1_valid=1, dep1=5. Same-cycle commit(x6, tag 0) + rename(x6, tag 3) -> x6 stays busy with tag 3.
- Rename x7, x8; assert clear with commit(x9, val 9) and dec_ready(rd=10) -> x7, x8, x10 not busy, x9=9. Separately, rdy_in=0 with dec_ready and commit -> no state change.
- Commit reg 0, val 0xFFFF, and rename rd=0 -> x0 reads 0, dep_valid=0. Assert rst_in asynchronously mid-stream -> all reads 0 before the next clock edge.

Source files
------------

// File: rtl/reg_file_rename.sv
// reg_file_rename: architectural register file with per-register ROB rename tags
// Ports:
//   clk_in, rst_in (async, active-high), rdy_in (global stall when low), clear (flush)
//   dec_*    : issue-side operand indices, destination and allocated ROB id
//   val*/dep*: resolved operand value or the ROB id still to wait on
//   search_* : ROB lookup of the tag currently mapped to each source
//   commit_* : ROB retirement writing architectural state
module reg_file_rename #(
  parameter int ROB_WIDTH = 3
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 rdy_in,
  input  logic                 clear,
  input  logic                 dec_ready,
  input  logic [4:0]           dec_rs1,
  input  logic [4:0]           dec_rs2,
  input  logic [4:0]           dec_rd,
  input  logic [ROB_WIDTH-1:0] dec_rob_id,
  output logic [31:0]          val1,
  output logic                 dep1_valid,
  output logic [ROB_WIDTH-1:0] dep1,
  output logic [31:0]          val2,
  output logic                 dep2_valid,
  output logic [ROB_WIDTH-1:0] dep2,
  output logic [ROB_WIDTH-1:0] search_rob_id_1,
  output logic [ROB_WIDTH-1:0] search_rob_id_2,
  input  logic                 search_ready_1,
  input  logic [31:0]          search_val_1,
  input  logic                 search_ready_2,
  input  logic [31:0]          search_val_2,
  input  logic                 commit_ready,
  input  logic [ROB_WIDTH-1:0] commit_rob_id,
  input  logic [4:0]           commit_reg_id,
  input  logic [31:0]          commit_val
);
  logic [31:0][31:0]          value;
  logic [31:0]                busy;
  logic [31:0][ROB_WIDTH-1:0] tag;
  logic                       hit1, hit2;
  assign search_rob_id_1 = tag[dec_rs1];
  assign search_rob_id_2 = tag[dec_rs2];
  assign dep1 = tag[dec_rs1];
  assign dep2 = tag[dec_rs2];
  // Bypass only when the retiring instruction is the one the mapping still waits on.
  assign hit1 = commit_ready && commit_reg_id == dec_rs1 && commit_rob_id == tag[dec_rs1];
  assign hit2 = commit_ready && commit_reg_id == dec_rs2 && commit_rob_id == tag[dec_rs2];
  always_comb begin
    val1 = dec_rs1 == 5'd0 ? 32'd0 : !busy[dec_rs1] ? value[dec_rs1] : hit1 ? commit_val : search_ready_1 ? search_val_1 : 32'd0;
    dep1_valid = dec_rs1 != 5'd0 && busy[dec_rs1] && !hit1 && !search_ready_1;
    val2 = dec_rs2 == 5'd0 ? 32'd0 : !busy[dec_rs2] ? value[dec_rs2] : hit2 ? commit_val : search_ready_2 ? search_val_2 : 32'd0;
    dep2_valid = dec_rs2 != 5'd0 && busy[dec_rs2] && !hit2 && !search_ready_2;
  end
  // Later nonblocking writes win: clear overrides commit's busy release, rename overrides commit.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      value <= '0;
      busy  <= '0;
      tag   <= '0;
    end else if (rdy_in) begin
      if (commit_ready && commit_reg_id != 5'd0) begin
        value[commit_reg_id] <= commit_val;
        if (tag[commit_reg_id] == commit_rob_id) busy[commit_reg_id] <= 1'b0;
      end
      if (clear) busy <= '0;
      else if (dec_ready && dec_rd != 5'd0) begin
        busy[dec_rd] <= 1'b1;
        tag[dec_rd]  <= dec_rob_id;
      end
    end
  end
endmodule

// File: tb/tb_reg_file_rename.sv
// tb_reg_file_rename: table-driven scoreboard bench for reg_file_rename
module tb_reg_file_rename;
  localparam int RW = 3;
  logic          clk_in = 1'b0;
  logic          rst_in, rdy_in, clear, dec_ready;
  logic [4:0]    dec_rs1, dec_rs2, dec_rd;
  logic [RW-1:0] dec_rob_id;
  logic [31:0]   val1, val2;
  logic          dep1_valid, dep2_valid;
  logic [RW-1:0] dep1, dep2, search_rob_id_1, search_rob_id_2;
  logic          search_ready_1, search_ready_2;
  logic [31:0]   search_val_1, search_val_2;
  logic          commit_ready;
  logic [RW-1:0] commit_rob_id;
  logic [4:0]    commit_reg_id;
  logic [31:0]   commit_val;
  always #5 clk_in = ~clk_in;
  reg_file_rename #(.ROB_WIDTH(RW)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear(clear),
    .dec_ready(dec_ready), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_rd(dec_rd), .dec_rob_id(dec_rob_id),
    .val1(val1), .dep1_valid(dep1_valid), .dep1(dep1),
    .val2(val2), .dep2_valid(dep2_valid), .dep2(dep2),
    .search_rob_id_1(search_rob_id_1), .search_rob_id_2(search_rob_id_2),
    .search_ready_1(search_ready_1), .search_val_1(search_val_1),
    .search_ready_2(search_ready_2), .search_val_2(search_val_2),
    .commit_ready(commit_ready), .commit_rob_id(commit_rob_id),
    .commit_reg_id(commit_reg_id), .commit_val(commit_val)
  );
  typedef struct packed {
    logic [31:0] v1; logic d1v; logic [RW-1:0] s1;
    logic [31:0] v2; logic d2v; logic [RW-1:0] s2;
  } out_t;
  typedef struct {
    logic rdy, clr, dr; logic [4:0] rd; logic [RW-1:0] rob; logic [4:0] rs1, rs2;
    logic sr1; logic [31:0] sv1; logic sr2; logic [31:0] sv2;
    logic cr; logic [RW-1:0] crob; logic [4:0] creg; logic [31:0] cval; out_t e;
  } vec_t;
  out_t sb[$];
  vec_t tbl[$];
  int   n = 0, errs = 0;
  // Expected dep equals the expected search id whenever the operand is pending.
  function automatic vec_t mk(input logic rdy, clr, dr, input logic [4:0] rd, input logic [RW-1:0] rob,
      input logic [4:0] rs1, rs2, input logic sr1, input logic [31:0] sv1, input logic sr2, input logic [31:0] sv2,
      input logic cr, input logic [RW-1:0] crob, input logic [4:0] creg, input logic [31:0] cval, v1,
      input logic d1v, input logic [31:0] v2, input logic d2v, input logic [RW-1:0] s1, s2);
    vec_t x;
    x.rdy = rdy; x.clr = clr; x.dr = dr; x.rd = rd; x.rob = rob; x.rs1 = rs1; x.rs2 = rs2;
    x.sr1 = sr1; x.sv1 = sv1; x.sr2 = sr2; x.sv2 = sv2;
    x.cr = cr; x.crob = crob; x.creg = creg; x.cval = cval;
    x.e = '{v1, d1v, s1, v2, d2v, s2};
    return x;
  endfunction
  task automatic drive(input vec_t x);
    rdy_in = x.rdy; clear = x.clr; dec_ready = x.dr; dec_rd = x.rd; dec_rob_id = x.rob;
    dec_rs1 = x.rs1; dec_rs2 = x.rs2;
    search_ready_1 = x.sr1; search_val_1 = x.sv1; search_ready_2 = x.sr2; search_val_2 = x.sv2;
    commit_ready = x.cr; commit_rob_id = x.crob; commit_reg_id = x.creg; commit_val = x.cval;
    sb.push_back(x.e);
  endtask
  task automatic sample(input string name);
    out_t e;
    logic ok;
    n++;
    if (sb.size() == 0) begin
      errs++;
      $display("FAIL %s: scoreboard empty, no expected value queued", name);
    end else begin
      e = sb.pop_front();
      ok = val1 === e.v1 && dep1_valid === e.d1v && search_rob_id_1 === e.s1 && (!e.d1v || dep1 === e.s1) &&
           val2 === e.v2 && dep2_valid === e.d2v && search_rob_id_2 === e.s2 && (!e.d2v || dep2 === e.s2);
      if (!ok) begin
        errs++;
        $display("FAIL %s: got v1=%h d1v=%b dep1=%h s1=%h v2=%h d2v=%b dep2=%h s2=%h; want v1=%h d1v=%b dep1/s1=%h v2=%h d2v=%b dep2/s2=%h",
                 name, val1, dep1_valid, dep1, search_rob_id_1, val2, dep2_valid, dep2, search_rob_id_2,
                 e.v1, e.d1v, e.s1, e.v2, e.d2v, e.s2);
      end
    end
  endtask
  initial begin
    // rdy clr dr rd rob | rs1 rs2 | sr1 sv1 sr2 sv2 | cr crob creg cval | v1 d1v v2 d2v s1 s2
    tbl.push_back(mk(1,0,0, 0,0,  5, 0, 0,0,     0,0,     0,0,0,0,         0,     0, 0,     0, 0,0));
    tbl.push_back(mk(1,0,1, 3,2,  3, 0, 0,0,     0,0,     0,0,0,0,         0,     0, 0,     0, 0,0));
    tbl.push_back(mk(1,0,0, 0,0,  3, 0, 0,0,     0,0,     0,0,0,0,         0,     1, 0,     0, 2,0));
    tbl.push_back(mk(1,0,0, 0,0,  3, 0, 1,'h55,  0,0,     0,0,0,0,         'h55,  0, 0,     0, 2,0));
    tbl.push_back(mk(1,0,0, 0,0,  3, 3, 0,0,     0,0,     1,2,3,'h1234,    'h1234,0, 'h1234,0, 2,2));
    tbl.push_back(mk(1,0,0, 0,0,  3, 0, 0,0,     0,0,     0,0,0,0,         'h1234,0, 0,     0, 2,0));
    tbl.push_back(mk(1,0,1, 4,1,  4, 0, 0,0,     0,0,     0,0,0,0,         0,     0, 0,     0, 0,0));
    tbl.push_back(mk(1,0,1, 4,5,  4, 0, 0,0,     0,0,     0,0,0,0,         0,     1, 0,     0, 1,0));
    tbl.push_back(mk(1,0,0, 0,0,  4, 0, 0,0,     0,0,     1,1,4,7,         0,     1, 0,     0, 5,0));
    tbl.push_back(mk(1,0,0, 0,0,  4, 4, 0,0,     1,'h99,  0,0,0,0,         0,     1, 'h99,  0, 5,5));
    tbl.push_back(mk(1,0,1, 6,0,  6, 0, 0,0,     0,0,     0,0,0,0,         0,     0, 0,     0, 0,0));
    tbl.push_back(mk(1,0,1, 6,3,  6, 0, 0,0,     0,0,     1,0,6,'h66,      'h66,  0, 0,     0, 0,0));
    tbl.push_back(mk(1,0,0, 0,0,  6, 0, 0,0,     0,0,     0,0,0,0,         0,     1, 0,     0, 3,0));
    tbl.push_back(mk(1,0,1, 7,4,  0, 0, 0,0,     0,0,     0,0,0,0,         0,     0, 0,     0, 0,0));
    tbl.push_back(mk(1,0,1, 8,6,  7, 0, 0,0,     0,0,     0,0,0,0,         0,     1, 0,     0, 4,0));
    tbl.push_back(mk(1,1,1,10,7,  8, 9, 0,0,     0,0,     1,7,9,9,         0,     1, 0,     0, 6,0));
    tbl.push_back(mk(1,0,0, 0,0,  7, 8, 0,0,     0,0,     0,0,0,0,         0,     0, 0,     0, 4,6));
    tbl.push_back(mk(1,0,0, 0,0, 10, 9, 0,0,     0,0,     0,0,0,0,         0,     0, 9,     0, 0,0));
    tbl.push_back(mk(1,0,0, 0,0,  4, 6, 0,0,     0,0,     0,0,0,0,         7,     0, 'h66,  0, 5,3));
    tbl.push_back(mk(1,0,1,13,1,  0, 0, 0,0,     0,0,     0,0,0,0,         0,     0, 0,     0, 0,0));
    tbl.push_back(mk(0,1,1,11,2, 13,11, 0,0,     0,0,     1,1,13,'hAB,     'hAB,  0, 0,     0, 1,0));
    tbl.push_back(mk(1,0,0, 0,0, 13,11, 0,0,     0,0,     0,0,0,0,         0,     1, 0,     0, 1,0));
    tbl.push_back(mk(1,0,1, 0,5,  0, 0, 0,0,     0,0,     1,0,0,'hFFFF,    0,     0, 0,     0, 0,0));
    tbl.push_back(mk(1,0,0, 0,0,  0, 0, 0,0,     0,0,     0,0,0,0,         0,     0, 0,     0, 0,0));
    rst_in = 1'b1;
    drive(mk(1,0,0,0,0, 5,0, 0,0,0,0, 0,0,0,0, 0,0,0,0,0,0));
    #2 sample("reset_state");
    @(negedge clk_in);
    rst_in = 1'b0;
    foreach (tbl[i]) begin
      @(negedge clk_in);
      drive(tbl[i]);
      #1 sample($sformatf("vec%0d", i));
    end
    @(negedge clk_in);
    drive(mk(1,0,0,0,0, 4,13, 0,0,0,0, 0,0,0,0, 7,0,0,1,5,1));
    #1 sample("pre_reset");
    #1 rst_in = 1'b1;
    drive(mk(1,0,1,13,3, 4,13, 0,0,0,0, 1,5,4,'h5A, 0,0,0,0,0,0));
    #1 sample("async_reset");
    @(negedge clk_in);
    rst_in = 1'b0;
    drive(mk(1,0,0,0,0, 4,13, 0,0,0,0, 0,0,0,0, 0,0,0,0,0,0));
    #1 sample("commit_lost");
    @(negedge clk_in);
    drive(mk(1,0,0,0,0, 4,13, 0,0,0,0, 0,0,0,0, 0,0,0,0,0,0));
    #1 sample("post_release");
    $display("== %0d vectors applied, %0d miscompares ==", n, errs);
    $finish;
  end
  initial begin
    #20000;
    $display("FAIL watchdog: bench did not finish within time limit");
    $fatal(1);
  end
endmodule
